// File: rtl/nf10_id_reader.sv
// nf10_id_reader: AXI4-Lite read-only master that fetches NUM_WORDS consecutive 32-bit
// identification words starting at C_TARGET_BASEADDR. It issues one in-order read at a time
// and presents the result as a parallel vector.
//
// Optional feature: define NF10_ID_READER_TIMEOUT_EN to enable an R-phase watchdog. When it
// fires, the run ends with timeout=1/error=1, and the late beat is drained and discarded
// before the block accepts a new start.
//
// Ports:
//   M_AXI_ACLK, M_AXI_ARESETN  clock, async active-low reset
//   start                      one-cycle run request, accepted only when busy=0
//   busy                       run in progress, or a stale beat is still pending
//   done                       one-cycle pulse at the end of a run
//   error, timeout             status of the last run, cleared by the next accepted start
//   id_words                   word i at [32*i +: 32]
//   M_AXI_AR*, M_AXI_R*        AXI4-Lite read channels (32-bit data only)
module nf10_id_reader #(
  parameter int unsigned                   C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_TARGET_BASEADDR  = '0,
  parameter int unsigned                   NUM_WORDS          = 5,
  parameter int unsigned                   C_TIMEOUT_CYCLES   = 256
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic                          timeout,
  output logic [NUM_WORDS*32-1:0]       id_words,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [31:0]                   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  output logic [2:0]                    M_AXI_ARPROT
);

  typedef enum logic [1:0] {StIdle, StAr, StR, StDone} state_e;

  state_e                        state_q;
  logic [3:0]                    idx_q;
  logic [31:0]                   words_q [NUM_WORDS];
  logic                          busy_q;
  logic                          done_q;
  logic                          error_q;
  logic                          arvalid_q;
  logic                          rready_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q;
`ifdef NF10_ID_READER_TIMEOUT_EN
  logic                          timeout_q;
  logic                          stale_q;
  logic [31:0]                   timer_q;
`endif

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      araddr_q  <= '0;
      for (int i = 0; i < int'(NUM_WORDS); i++) words_q[i] <= '0;
`ifdef NF10_ID_READER_TIMEOUT_EN
      timeout_q <= 1'b0;
      stale_q   <= 1'b0;
      timer_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !busy_q) begin
            for (int i = 0; i < int'(NUM_WORDS); i++) words_q[i] <= '0;
            error_q   <= 1'b0;
            idx_q     <= '0;
            araddr_q  <= C_TARGET_BASEADDR;
            arvalid_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= StAr;
`ifdef NF10_ID_READER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
          end
        end
        StAr: begin
          // ARVALID/ARADDR are held untouched until the handshake.
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StR;
`ifdef NF10_ID_READER_TIMEOUT_EN
            timer_q   <= '0;
`endif
          end
        end
        StR: begin
          if (M_AXI_RVALID) begin
            // A failed response leaves the word zero and flags the run; the run continues.
            for (int i = 0; i < int'(NUM_WORDS); i++) begin
              if (idx_q == 4'(i)) words_q[i] <= (M_AXI_RRESP == 2'b00) ? M_AXI_RDATA : 32'h0;
            end
            if (M_AXI_RRESP != 2'b00) error_q <= 1'b1;
            rready_q <= 1'b0;
            if (idx_q == 4'(NUM_WORDS - 1)) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              idx_q     <= idx_q + 4'd1;
              araddr_q  <= araddr_q + C_M_AXI_ADDR_WIDTH'(4);  // wraps modulo 2^ADDR_WIDTH
              arvalid_q <= 1'b1;
              state_q   <= StAr;
            end
          end
`ifdef NF10_ID_READER_TIMEOUT_EN
          else if (timer_q == C_TIMEOUT_CYCLES - 1) begin
            // Abort; RREADY stays high so the late beat is swallowed while stale.
            timeout_q <= 1'b1;
            error_q   <= 1'b1;
            stale_q   <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
`endif
        end
        StDone: begin
          state_q <= StIdle;
`ifdef NF10_ID_READER_TIMEOUT_EN
          busy_q  <= stale_q;
`else
          busy_q  <= 1'b0;
`endif
        end
        default: state_q <= StIdle;
      endcase
`ifdef NF10_ID_READER_TIMEOUT_EN
      // Stale beat can only arrive in StDone/StIdle; start is blocked until it is gone.
      if (stale_q && M_AXI_RVALID) begin
        stale_q  <= 1'b0;
        rready_q <= 1'b0;
        busy_q   <= 1'b0;
      end
`endif
    end
  end

  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_pack
    assign id_words[32*g +: 32] = words_q[g];
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
  assign M_AXI_ARPROT  = 3'b000;
`ifdef NF10_ID_READER_TIMEOUT_EN
  assign timeout       = timeout_q;
`else
  assign timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_nf10_id_reader.sv
`timescale 1ns/1ps
module tb_nf10_id_reader;
  localparam int unsigned NW     = 5;
  localparam logic [31:0] BASE   = 32'hFFFF_FFF8;  // run wraps through address 0
  localparam int unsigned TO_CYC = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              busy, done, error, timeout;
  logic [NW*32-1:0]  id_words;
  logic [31:0]       araddr;
  logic              arvalid, arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid, rready;
  logic [2:0]        arprot;

  always #5 clk = ~clk;

  nf10_id_reader #(
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_ADDR_WIDTH(32),
    .C_TARGET_BASEADDR (BASE),
    .NUM_WORDS         (NW),
    .C_TIMEOUT_CYCLES  (TO_CYC)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(rst_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .timeout      (timeout),
    .id_words     (id_words),
    .M_AXI_ARADDR (araddr),
    .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA  (rdata),
    .M_AXI_RRESP  (rresp),
    .M_AXI_RVALID (rvalid),
    .M_AXI_RREADY (rready),
    .M_AXI_ARPROT (arprot)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [NW*32-1:0] act, input logic [NW*32-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave contents and per-run expectations
  logic [31:0] mem [NW];
  bit          bad [NW];
  int          r_extra [NW];
  bit          bp_en = 0;
  int          exp_nvalid, exp_ar, exp_r;
  bit          exp_error, exp_timeout;

  function automatic logic [NW*32-1:0] exp_vec();
    logic [NW*32-1:0] v;
    v = '0;
    for (int i = 0; i < exp_nvalid; i++) v[32*i +: 32] = bad[i] ? 32'h0 : mem[i];
    return v;
  endfunction

  task automatic set_normal();
    exp_nvalid = NW; exp_ar = NW; exp_r = NW; exp_error = 0; exp_timeout = 0;
    for (int i = 0; i < NW; i++) begin
      exp_error = exp_error | bad[i];
    end
  endtask

  // Slave: decides ARREADY/RVALID #1 after each edge from the DUT's registered outputs.
  int ar_hs = 0, r_hs = 0;
  bit r_pending = 0;
  int r_delay = 0, ar_delay = 0, r_idx = 0;

  initial begin
    arready = 0; rvalid = 0; rdata = '0; rresp = '0;
    forever begin
      @(posedge clk); #1;
      arready = 0; rvalid = 0;
      if (!rst_n) begin
        r_pending = 0; ar_delay = 0;
      end else if (r_pending) begin
        if (r_delay > 0) r_delay--;
        else begin
          rvalid = 1; rdata = mem[r_idx]; rresp = bad[r_idx] ? 2'b10 : 2'b00;
          if (rready) begin r_pending = 0; r_hs++; end
        end
      end else if (arvalid) begin
        if (ar_delay > 0) ar_delay--;
        else begin
          arready   = 1;
          r_pending = 1;
          r_idx     = int'((araddr - BASE) >> 2);
          if (r_idx >= NW) r_idx = 0;
          r_delay   = (bp_en ? int'($urandom_range(0, 7)) : 0) + r_extra[r_idx];
          ar_delay  = bp_en ? int'($urandom_range(0, 7)) : 0;
          ar_hs++;
        end
      end
    end
  end

  // Compare process: protocol and end-of-run results against the model.
  int cyc = 0, start_cyc = 0, done_cyc = 0, n_done = 0, run_ar = 0;
  bit prev_stall = 0;
  logic [31:0] prev_addr = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("arprot", {157'b0, arprot}, '0);
      if (prev_stall) begin
        chk("arvalid_hold", {159'b0, arvalid}, 1);
        chk("araddr_hold", {128'b0, araddr}, {128'b0, prev_addr});
      end
      if (arvalid && arready) begin
        chk("araddr_seq", {128'b0, araddr}, {128'b0, BASE + 32'(4 * run_ar)});
        run_ar++;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        chk("id_words", id_words, exp_vec());
        chk("error", {159'b0, error}, {159'b0, exp_error});
        chk("timeout", {159'b0, timeout}, {159'b0, exp_timeout});
        chk("ar_count", ar_hs, exp_ar);
        chk("r_count", r_hs, exp_r);
      end
      prev_stall = arvalid && !arready;
      prev_addr  = araddr;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic run(input int budget, input bit extra, input bit busy_after, output int lat);
    int c;
    int n0;
    run_ar = 0; ar_hs = 0; r_hs = 0;
    n0 = n_done;
    @(posedge clk); #1;
    start = 1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 0;
    c = 0;
    while (n_done == n0 && c < budget) begin
      @(negedge clk); #1;
      c++;
      start = extra && (c == 4);
    end
    chk("done_seen", n_done - n0, 1);
    lat = done_cyc - start_cyc;
    chk("busy_in_done", {159'b0, busy}, 1);
    start = extra;  // start in the done cycle must be ignored
    @(negedge clk); #1;
    start = 0;
    chk("busy_after_done", {159'b0, busy}, {159'b0, busy_after});
  endtask

  int lat;
  int n_before;
  int c;

  initial begin
    mem[0] = 32'h20240115; mem[1] = 32'h00123456; mem[2] = 32'h0000CAFE;
    mem[3] = 32'h00000001; mem[4] = 32'h00000003;
    for (int i = 0; i < NW; i++) begin bad[i] = 0; r_extra[i] = 0; end
    set_normal();
    rst_n = 0; start = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk); #1;
    chk("rst_busy", {159'b0, busy}, 0);
    chk("rst_done", {159'b0, done}, 0);
    chk("rst_error", {159'b0, error}, 0);
    chk("rst_timeout", {159'b0, timeout}, 0);
    chk("rst_id_words", id_words, '0);
    chk("rst_arvalid_rready", {158'b0, arvalid, rready}, 0);
    chk("rst_araddr", {128'b0, araddr}, 0);

    // Zero-wait run
    run(50, 0, 0, lat);
    chk("latency", lat, 11);
    chk("word0_literal", {128'b0, id_words[31:0]}, {128'b0, 32'h20240115});
    chk("word4_literal", {128'b0, id_words[159:128]}, {128'b0, 32'h00000003});
    chk("idle_rready", {159'b0, rready}, 0);

    // Extra starts during the run and in the done cycle
    n_before = n_done;
    run(50, 1, 0, lat);
    chk("latency_extra_start", lat, 11);
    repeat (15) @(negedge clk);
    #1;
    chk("single_run", n_done - n_before, 1);
    chk("no_rerun_arvalid", {159'b0, arvalid}, 0);

    // Random backpressure
    bp_en = 1;
    run(300, 0, 0, lat);
    bp_en = 0;

    // Error response on word 2
    bad[2] = 1; set_normal();
    run(50, 0, 0, lat);
    chk("word2_zero_literal", {128'b0, id_words[95:64]}, 0);
    chk("word3_literal", {128'b0, id_words[127:96]}, {128'b0, 32'h00000001});
    bad[2] = 0; set_normal();
    run(50, 0, 0, lat);
    chk("error_cleared", {159'b0, error}, 0);

`ifdef NF10_ID_READER_TIMEOUT_EN
    // Withhold word 1; watchdog ends the run, late beat drained afterwards
    r_extra[1] = 30;
    exp_nvalid = 1; exp_ar = 2; exp_r = 1; exp_error = 1; exp_timeout = 1;
    run(100, 0, 1, lat);
    chk("timeout_latency", lat, 3 + TO_CYC + 1);
    repeat (4) @(negedge clk);
    #1;
    start = 1;
    chk("stale_busy", {159'b0, busy}, 1);
    chk("stale_rready", {159'b0, rready}, 1);
    @(negedge clk); #1;
    start = 0;
    c = 0;
    while (r_pending && c < 100) begin @(negedge clk); #1; c++; end
    chk("stale_beat_seen", {159'b0, r_pending}, 0);
    @(negedge clk); #1;
    chk("drained_busy", {159'b0, busy}, 0);
    chk("drained_rready", {159'b0, rready}, 0);
    chk("drained_r_count", r_hs, 2);
    chk("start_ignored_stale", {159'b0, arvalid}, 0);
    r_extra[1] = 0; set_normal();
    run(50, 0, 0, lat);
    chk("post_timeout_latency", lat, 11);
    chk("post_timeout_flag", {159'b0, timeout}, 0);
`endif

    // Reset mid-R on word 2
    r_extra[2] = 20; set_normal();
    run_ar = 0; ar_hs = 0; r_hs = 0;
    n_before = n_done;
    @(posedge clk); #1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    c = 0;
    while (run_ar < 3 && c < 50) begin @(negedge clk); #1; c++; end
    repeat (3) @(negedge clk);
    #1;
    chk("pre_reset_rready", {159'b0, rready}, 1);
    #1;
    rst_n = 0;
    #1;
    chk("mid_reset_busy_done", {158'b0, busy, done}, 0);
    chk("mid_reset_err_to", {158'b0, error, timeout}, 0);
    chk("mid_reset_id_words", id_words, '0);
    chk("mid_reset_axi", {126'b0, araddr, arvalid, rready}, 0);
    repeat (5) @(negedge clk);
    chk("no_done_in_reset", n_done - n_before, 0);
    rst_n = 1;
    r_extra[2] = 0;
    repeat (2) @(negedge clk);
    run(50, 0, 0, lat);
    chk("post_reset_latency", lat, 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nf10_id_reader.md
# nf10_id_reader

AXI4-Lite read-only master that fetches a block of consecutive 32-bit identification words (date, time, project ID, tag, board ID) from an identifier register slave and presents them as a parallel vector. It sits on the initiator side of the AXI-Lite register bus, driven by local control logic or a self-test sequencer. On each `start` it performs one in-order, single-outstanding read per word, then pulses `done`.

## Interface
- `C_M_AXI_DATA_WIDTH`, 32, data width; only 32 is supported.
- `C_M_AXI_ADDR_WIDTH`, 32, address width.
- `C_TARGET_BASEADDR`, 32'h00000000, byte address of word 0.
- `NUM_WORDS`, 5, words fetched per run, 1..16.
- `C_TIMEOUT_CYCLES`, 256, R-phase wait limit, used only with the timeout feature.

- `M_AXI_ACLK` in 1: the only clock.
- `M_AXI_ARESETN` in 1: reset. Asynchronous assert, active-low.
- `start` in 1: one-cycle request; accepted only when `busy`=0.
- `busy` out 1: run in progress or stale beat pending.
- `done` out 1: one-cycle pulse at end of run.
- `error` out 1: the last run saw a non-OKAY RRESP or a timeout. Cleared on the next accepted `start`.
- `timeout` out 1: the last run was aborted by the watchdog. Cleared on the next accepted `start`.
- `id_words` out NUM_WORDS*32: word i is at bits [32*i +: 32].
- `M_AXI_ARADDR` out C_M_AXI_ADDR_WIDTH: read address.
- `M_AXI_ARVALID` out 1: read address valid.
- `M_AXI_ARREADY` in 1: read address ready.
- `M_AXI_RDATA` in 32: read data.
- `M_AXI_RRESP` in 2: read response.
- `M_AXI_RVALID` in 1: read data valid.
- `M_AXI_RREADY` out 1: read data ready.
- `M_AXI_ARPROT` out 3: constant 3'b000.

## Operation
States and transitions:
- IDLE: on `start` with `busy`=0:
  - clear `id_words`, `error` and `timeout`;
  - set idx=0;
  - go to AR.
- AR: `ARVALID`=1, `ARADDR`=C_TARGET_BASEADDR + 4*idx.
  - ARADDR and ARVALID are registered and stable until the ARVALID&ARREADY handshake; ARVALID is never dropped early.
  - On handshake, go to R.
- R: `RREADY`=1.
  - On RVALID&RREADY with RRESP==2'b00, store RDATA into word idx.
  - With RRESP!=2'b00, store 32'h0 and set `error` (sticky for the run); the run continues.
  - If idx==NUM_WORDS-1, go to DONE; otherwise idx+1 and go to AR.
- DONE: `done`=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^C_M_AXI_ADDR_WIDTH (wraps, no error).
- `start` while `busy`=1 is ignored, not queued.
- Exactly one transaction is outstanding at any time.
- RVALID in IDLE, AR or DONE with no stale beat pending is ignored; RREADY stays 0 there.

## Timing
- Reset values: all outputs 0, including `id_words`. State is IDLE, idx=0, stale=0.
- `start` is sampled at cycle 0. ARVALID is high from cycle 1.
- `busy` is high from cycle 1 until the cycle after `done`.
- Against a zero-wait slave (ARREADY=1, RVALID the cycle after the AR handshake), each word costs 2 cycles.
  - For NUM_WORDS=5: the last R handshake is in cycle 10 and `done` is high in cycle 11.
- `id_words`, `error` and `timeout` are valid when `done`=1 and hold until the next accepted `start`.
- A reset assertion mid-run returns all state to reset values asynchronously. No `done` is produced.

## Configuration
- `NF10_ID_READER_TIMEOUT_EN` defined:
  - A counter runs in R. If C_TIMEOUT_CYCLES cycles pass without the R handshake:
    - set `timeout` and `error`;
    - set stale=1;
    - go to DONE.
  - While stale=1, RREADY=1 in every state except R, and `busy`=1.
  - The next RVALID beat is discarded and clears stale.
  - AR has no timeout, to preserve ARVALID stability.
- Macro undefined:
  - No counter and no stale logic; the block waits in R indefinitely.
  - `timeout` is tied to 0.

## Test plan
- Zero-wait slave returning 32'h20240115, 32'h00123456, 32'h0000CAFE, 32'h00000001, 32'h00000003 -> `done` in cycle 11 after `start`; `id_words` equals those words in order; ARADDR sequence is base+0, +4, +8, +C, +10; `error`=0.
- Random ARREADY/RVALID backpressure of 0-7 cycles -> ARADDR and ARVALID stable until handshake; same `id_words` result; exactly 5 AR and 5 R handshakes.
- RRESP=2'b10 on word 2 -> word 2 reads 32'h0; other words are correct; `error`=1 at `done`; the next run with OKAY responses clears `error`.
- `start` pulsed during a run, and again in the `done` cycle -> ignored; only one run occurs.
- With the macro defined and C_TIMEOUT_CYCLES=16, withhold RVALID on word 1 -> `done` with `timeout`=1 and `error`=1; `busy` stays 1 until the late RVALID is drained with RREADY=1; a new `start` then completes normally.
- Assert M_AXI_ARESETN low mid-R -> all outputs 0 immediately; no `done`; a fresh run after reset passes.
